// File: rtl/block_sync.sv
// Per-lane sync-header block-lock stage: acquires/maintains block lock from
// 2-bit sync headers and requests single-bit slips from the gearbox.
module block_sync #(
  parameter int unsigned LOCK_CNT       = 64,
  parameter int unsigned UNLOCK_WINDOW  = 1024,
  parameter int unsigned UNLOCK_INVALID = 65,
  parameter int unsigned SLIP_WAIT      = 4
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_valid,
  input  logic [1:0] i_sh,
  input  logic       i_enable,
  output logic       o_valid,
  output logic       o_valid_sh,
  output logic       o_block_lock,
  output logic       o_slip
);

  localparam int unsigned CW = $clog2(UNLOCK_WINDOW) + 1;
  localparam int unsigned WW = $clog2(SLIP_WAIT) + 1;

  typedef enum logic [3:0] {
    LOCK_INIT = 4'b0001,
    HUNT      = 4'b0010,
    SLIP_WT   = 4'b0100,
    LOCKED    = 4'b1000
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_sh_cnt;
  logic [CW-1:0]   r_inv_cnt;
  logic [WW-1:0]   r_wait_cnt;
  logic            r_valid;
  logic            r_valid_sh;
  logic            r_lock;
  logic            r_slip;

  logic            w_sh_ok;
  logic [CW-1:0]   w_sh_inc;
  logic [CW-1:0]   w_inv_inc;
  logic [WW-1:0]   w_wait_inc;
  logic            w_lock_hit;
  logic            w_win_end;
  logic            w_unlock;
  logic            w_wait_done;

  assign w_sh_ok     = i_sh[1] ^ i_sh[0];
  assign w_sh_inc    = r_sh_cnt + CW'(1);
  assign w_inv_inc   = r_inv_cnt + CW'(1);
  assign w_wait_inc  = r_wait_cnt + WW'(1);
  assign w_lock_hit  = (w_sh_inc == CW'(LOCK_CNT));
  assign w_win_end   = (w_sh_inc == CW'(UNLOCK_WINDOW));
  assign w_unlock    = !w_sh_ok && (w_inv_inc == CW'(UNLOCK_INVALID));
  assign w_wait_done = (w_wait_inc == WW'(SLIP_WAIT));

  // Header forwarding is independent of lane enable and lock state.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid    <= 1'b0;
      r_valid_sh <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) r_valid_sh <= w_sh_ok;
    end
  end

  // Lock FSM; everything except LOCK_INIT advances only on valid blocks.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= LOCK_INIT;
      r_sh_cnt   <= '0;
      r_inv_cnt  <= '0;
      r_wait_cnt <= '0;
      r_lock     <= 1'b0;
      r_slip     <= 1'b0;
    end else begin
      r_slip <= 1'b0;
      if (!i_enable) begin
        r_state    <= LOCK_INIT;
        r_sh_cnt   <= '0;
        r_inv_cnt  <= '0;
        r_wait_cnt <= '0;
        r_lock     <= 1'b0;
      end else begin
        case (r_state)
          LOCK_INIT: begin
            r_sh_cnt   <= '0;
            r_inv_cnt  <= '0;
            r_wait_cnt <= '0;
            r_lock     <= 1'b0;
            r_state    <= HUNT;
          end
          HUNT: begin
            if (i_valid) begin
              if (!w_sh_ok) begin
                r_slip   <= 1'b1;
                r_sh_cnt <= '0;
                r_state  <= SLIP_WT;
              end else if (w_lock_hit) begin
                r_lock    <= 1'b1;
                r_sh_cnt  <= '0;
                r_inv_cnt <= '0;
                r_state   <= LOCKED;
              end else begin
                r_sh_cnt <= w_sh_inc;
              end
            end
          end
          SLIP_WT: begin
            if (i_valid) begin
              if (w_wait_done) begin
                r_wait_cnt <= '0;
                r_state    <= HUNT;
              end else begin
                r_wait_cnt <= w_wait_inc;
              end
            end
          end
          LOCKED: begin
            if (i_valid) begin
              // Unlock wins over a coincident window rollover.
              if (w_unlock) begin
                r_lock     <= 1'b0;
                r_slip     <= 1'b1;
                r_sh_cnt   <= '0;
                r_inv_cnt  <= '0;
                r_wait_cnt <= '0;
                r_state    <= SLIP_WT;
              end else if (w_win_end) begin
                r_sh_cnt  <= '0;
                r_inv_cnt <= '0;
              end else begin
                r_sh_cnt <= w_sh_inc;
                if (!w_sh_ok) r_inv_cnt <= w_inv_inc;
              end
            end
          end
          default: begin
            r_state    <= LOCK_INIT;
            r_sh_cnt   <= '0;
            r_inv_cnt  <= '0;
            r_wait_cnt <= '0;
            r_lock     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_valid      = r_valid;
  assign o_valid_sh   = r_valid_sh;
  assign o_block_lock = r_lock;
  assign o_slip       = r_slip;

endmodule

// File: doc/block_sync.md
Name: block_sync

Overview:
- Per-lane sync-header block-lock stage. Sits directly upstream of the BER monitor.
- Inspects the 2-bit sync header of every block delivered by the lane gearbox and acquires/maintains block lock, in the style of IEEE 802.3 Cl.82 lock_fsm.
- Issues single-cycle slip requests back to the gearbox.
- Forwards a registered valid strobe and per-block sync-header validity to the BER monitor and deskew stages.

Parameters:
- LOCK_CNT, 64: consecutive valid headers required to declare lock.
- UNLOCK_WINDOW, 1024: blocks per monitoring window while locked.
- UNLOCK_INVALID, 65: invalid headers within one window that drop lock.
- SLIP_WAIT, 4: valid blocks ignored after a slip, letting the gearbox realign.

Ports:
- i_clock, in, 1: core clock.
- i_reset_n, in, 1: asynchronous, active-low reset.
- i_valid, in, 1: gearbox block strobe; i_sh is meaningful only when high.
- i_sh, in, 2: sync header of current block; valid iff i_sh[1]^i_sh[0]=1.
- i_enable, in, 1: lane enable; low forces the FSM to LOCK_INIT synchronously.
- o_valid, out, 1: i_valid delayed 1 cycle.
- o_valid_sh, out, 1: (i_sh[1]^i_sh[0]) sampled when i_valid, delayed 1 cycle; holds last value when o_valid=0.
- o_block_lock, out, 1: lane block lock.
- o_slip, out, 1: one-cycle pulse requesting a 1-bit slip from the gearbox.

Behaviour:
- Reset: all outputs 0, state=LOCK_INIT, sh_cnt=0, inv_cnt=0, wait_cnt=0. Reset is asynchronous on assertion.
- Counter widths:
  - sh_cnt, inv_cnt: $clog2(UNLOCK_WINDOW)+1 bits.
  - wait_cnt: $clog2(SLIP_WAIT)+1 bits.
  - Counters never wrap; they are always cleared before reaching their limit.
- Counters and the FSM advance only on cycles with i_valid=1 (except LOCK_INIT). All outputs are registered.
- Define sh_ok = i_sh[1]^i_sh[0].
- LOCK_INIT (one-hot 4'b0001):
  - Clears counters, o_block_lock=0.
  - Unconditionally goes to HUNT next cycle, independent of i_valid.
- HUNT (4'b0010), per valid block:
  - sh_ok=1: sh_cnt+1. If sh_cnt+1 == LOCK_CNT: o_block_lock=1 next cycle, clear counters, go to LOCKED.
  - sh_ok=0: o_slip=1 next cycle (single cycle), clear sh_cnt, go to SLIP_WAIT.
- SLIP_WAIT (4'b0100):
  - o_slip deasserts after one cycle.
  - wait_cnt counts valid blocks; headers are ignored (o_valid_sh still forwarded).
  - When wait_cnt+1 == SLIP_WAIT: clear wait_cnt, go to HUNT.
  - o_block_lock unchanged (0 when entered from HUNT; cleared on entry from LOCKED).
- LOCKED (4'b1000), per valid block: sh_cnt+1; if sh_ok=0 also inv_cnt+1.
  - If inv_cnt+1 == UNLOCK_INVALID: o_block_lock=0 and o_slip=1 next cycle, clear counters, go to SLIP_WAIT.
  - Else if sh_cnt+1 == UNLOCK_WINDOW: clear both counters, stay LOCKED.
  - Unlock has priority when both conditions occur on the same block.
- Latency:
  - o_block_lock rises on the clock edge after the LOCK_CNT-th valid header is sampled.
  - o_slip is asserted in the cycle after the offending block.
  - o_valid and o_valid_sh lag the inputs by exactly 1 cycle.
- Slip spacing: o_slip never asserts in two consecutive cycles. Minimum spacing is SLIP_WAIT+1 valid blocks.
- i_enable=0:
  - Next cycle: state=LOCK_INIT, o_block_lock=0, o_slip=0, counters cleared.
  - o_valid/o_valid_sh keep forwarding.
- i_valid gaps (any length) freeze all counters and state; they do not reset them.
- Illegal one-hot state: recover to LOCK_INIT next cycle.
- Reset mid-operation:
  - Asynchronous clear of everything, including a pending o_slip.
  - After release, first lock no earlier than LOCK_CNT valid blocks plus 1 cycle.

Test Plan:
- Reset, then 64 valid blocks with i_sh=2'b01 every cycle -> o_block_lock=0 through block 63, =1 on the edge after block 64; o_slip never asserted.
- Hunt: 10 good headers then i_sh=2'b11 -> o_slip high for exactly 1 cycle; next 4 valid blocks (any i_sh) produce no slip; then 64 good -> lock.
- Locked window: after lock, 1024 blocks with 64 invalid headers spread evenly -> lock held, counters clear at window end; a second window with 65 invalid headers -> o_block_lock falls and o_slip pulses the cycle after the 65th invalid.
- Simultaneous: 65th invalid header placed on block 1024 of the window -> unlock wins (o_block_lock=0, o_slip=1).
- Gaps: lock acquisition with i_valid toggling 1/0 every cycle -> lock after 64 valid blocks (128 cycles); o_valid and o_valid_sh mirror inputs with 1-cycle delay.
- i_reset_n pulsed low asynchronously mid-LOCKED, and separately i_enable=0 for 1 cycle -> o_block_lock=0 immediately (reset) or next cycle (enable); relock requires a full 64 good headers.
